// File: rtl/sequenciador_regras_fuzzy.sv
// Rule scheduler: walks the fuzzy rule grid over the latched activity mask.
// Optional FUZZY_SKIP_INACTIVE_EN: inactive pairs take one blank cycle.
module sequenciador_regras_fuzzy #(
  parameter int N_SETS    = 3,
  parameter int DWELL_CYC = 2
) (
  input  logic                  clk_0,
  input  logic                  Srst,
  input  logic                  EN_REGRAS,
  input  logic [2*N_SETS-1:0]   Ativo,
  output logic [3:0]            Regras,
  output logic                  Reset_Inf,
  output logic                  clk_int,
  output logic                  Busy,
  output logic                  Done,
  output logic [4:0]            N_regras
);

`ifdef FUZZY_SKIP_INACTIVE_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  localparam logic [1:0] LAST = 2'(N_SETS - 1);
  localparam logic [3:0] DW   = 4'(DWELL_CYC);
  localparam logic [3:0] NONE = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SCAN, S_DWELL, S_DEFUZZ, S_DONE
  } state_t;

  state_t              state_q;
  logic [2*N_SETS-1:0] mask_q;
  logic [1:0]          i_q, j_q, i_d, j_d;
  logic [3:0]          cnt_q;
  logic [4:0]          run_q, run_d, run_adv;
  logic [3:0]          regras_q;
  logic                rinf_q, clki_q, busy_q, done_q;
  logic [4:0]          nreg_q;
  logic [N_SETS-1:0]   m1, m2;
  logic                act_cur, act_nxt, last_pair;
  logic                show_nxt, hold_cur;

  assign m1 = mask_q[N_SETS-1:0];
  assign m2 = mask_q[2*N_SETS-1:N_SETS];

  always_comb begin
    i_d = i_q;
    j_d = j_q + 2'd1;
    if (j_q == LAST) begin
      j_d = 2'd0;
      i_d = i_q + 2'd1;
    end
  end

  assign act_cur   = m1[i_q] & m2[j_q];
  assign act_nxt   = m1[i_d] & m2[j_d];
  assign last_pair = (i_q == LAST) && (j_q == LAST);
  assign show_nxt  = act_nxt | ~SKIP;
  assign hold_cur  = (act_cur | ~SKIP) && (DW > 4'd1);
  assign run_d     = run_q + {4'd0, act_cur};
  assign run_adv   = (state_q == S_SCAN) ? run_d : run_q;

  always_ff @(posedge clk_0 or posedge Srst) begin
    if (Srst) begin
      state_q  <= S_IDLE;
      mask_q   <= '0;
      i_q      <= 2'd0;
      j_q      <= 2'd0;
      cnt_q    <= 4'd0;
      run_q    <= 5'd0;
      regras_q <= NONE;
      rinf_q   <= 1'b0;
      clki_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      nreg_q   <= 5'd0;
    end else begin
      rinf_q <= 1'b0;
      clki_q <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (EN_REGRAS) begin
            mask_q  <= Ativo;
            state_q <= S_CLEAR;
            rinf_q  <= 1'b1;
            busy_q  <= 1'b1;
            i_q     <= 2'd0;
            j_q     <= 2'd0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_CLEAR: begin
          if (!EN_REGRAS) begin
            state_q  <= S_IDLE;
            regras_q <= NONE;
            busy_q   <= 1'b0;
          end else begin
            run_q    <= 5'd0;
            state_q  <= S_SCAN;
            regras_q <= (act_cur | ~SKIP) ? {i_q, j_q} : NONE;
          end
        end
        S_SCAN, S_DWELL: begin
          if (!EN_REGRAS) begin
            state_q  <= S_IDLE;
            regras_q <= NONE;
            busy_q   <= 1'b0;
            i_q      <= 2'd0;
            j_q      <= 2'd0;
          end else begin
            if (state_q == S_SCAN) run_q <= run_d;
            if (state_q == S_SCAN && hold_cur) begin
              state_q <= S_DWELL;
              cnt_q   <= DW - 4'd1;
            end else if (state_q == S_DWELL && cnt_q > 4'd1) begin
              cnt_q <= cnt_q - 4'd1;
            end else if (last_pair) begin
              state_q  <= S_DEFUZZ;
              regras_q <= NONE;
              clki_q   <= (run_adv != 5'd0);
              nreg_q   <= run_adv;
            end else begin
              state_q  <= S_SCAN;
              i_q      <= i_d;
              j_q      <= j_d;
              regras_q <= show_nxt ? {i_d, j_d} : NONE;
            end
          end
        end
        S_DEFUZZ: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Regras    = regras_q;
  assign Reset_Inf = rinf_q;
  assign clk_int   = clki_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign N_regras  = nreg_q;

endmodule
